// File: rtl/mux8_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter_if
// Brief    : Request/data/grant bundle shared by the 8:1 mux arbiter and
//            its eight requesters.
// Revision : 1.0 - initial release
// ============================================================================
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] e;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       y;
  logic       y_valid;
  logic       tmo;

  modport master (
    output req,
    output e,
    input  gnt,
    input  s,
    input  y,
    input  y_valid,
    input  tmo
  );

  modport slave (
    input  req,
    input  e,
    output gnt,
    output s,
    output y,
    output y_valid,
    output tmo
  );
endinterface
`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter
// Brief    : Round-robin owner arbiter and select sequencer for a shared
//            8:1 single-bit mux. Optional hold timeout: MUX8_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input wire logic          clk,
  input wire logic          rst_n,
  mux8_rr_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] s_q, s_d;
  logic [7:0] gnt_q, gnt_d;

  // First requester at or after p, scanning upward modulo 8; bit 3 = found.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [7:0] owner_mask;
  logic       owner_req;
  logic [2:0] ptr_next;
  logic [3:0] pick_idle;
  logic [3:0] pick_rel;
  logic       hold_expired;

  assign owner_mask = 8'(1) << s_q;
  assign owner_req  = bus.req[s_q];
  assign ptr_next   = s_q + 3'd1;
  assign pick_idle  = rr_pick(bus.req, ptr_q);
  assign pick_rel   = rr_pick(bus.req & ~owner_mask, ptr_next);

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign bus.tmo      = tmo_q;
`else
  logic unused_hold_max;

  assign unused_hold_max = (HOLD_MAX > 1);
  assign hold_expired    = 1'b0;
  assign bus.tmo         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
`ifdef MUX8_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_idle[3]) begin
          state_d = ST_GRANT;
          s_d     = pick_idle[2:0];
          gnt_d   = 8'(1) << pick_idle[2:0];
`ifdef MUX8_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (owner_req && !hold_expired) begin
`ifdef MUX8_ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end else begin
          // Voluntary or forced release: hand over without an idle gap if possible.
          ptr_d = ptr_next;
`ifdef MUX8_ARB_TIMEOUT_EN
          cnt_d = '0;
          tmo_d = owner_req;
`endif
          if (pick_rel[3]) begin
            s_d   = pick_rel[2:0];
            gnt_d = 8'(1) << pick_rel[2:0];
          end else if (!owner_req) begin
            state_d = ST_IDLE;
            gnt_d   = 8'h00;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      s_q     <= 3'd0;
      gnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef MUX8_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.gnt     = gnt_q;
  assign bus.s       = s_q;
  assign bus.y_valid = (state_q == ST_GRANT);
  assign bus.y       = (state_q == ST_GRANT) & bus.e[s_q];

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_rr_arbiter
// Brief    : Scoreboard bench for mux8_rr_arbiter (timeout scenarios only
//            when MUX8_ARB_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       cs;
    logic       v;
    logic       y;
    logic       tmo;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  exp_t ex;
  int   vectors;
  int   miscompares;

  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] g, input logic [2:0] s, input logic cs,
                              input logic v, input logic y, input logic t);
    exp_t r;
    r.gnt = g; r.s = s; r.cs = cs; r.v = v; r.y = y; r.tmo = t;
    return r;
  endfunction

  task automatic apply(input logic [7:0] r, input logic [7:0] ev);
    bus.req = r;
    bus.e   = ev;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    bus.e   = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 8'h00;
    bus.e   = 8'hFF;
    #1;
    sb.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    ex = sb.pop_front(); vectors++;
    if (bus.gnt !== ex.gnt || bus.s !== ex.s || bus.y_valid !== ex.v || bus.y !== ex.y || bus.tmo !== ex.tmo) begin
      miscompares++;
      $display("FAIL reset_in: gnt=%h s=%0d v=%b y=%b tmo=%b want gnt=%h s=%0d v=%b y=%b tmo=%b",
               bus.gnt, bus.s, bus.y_valid, bus.y, bus.tmo, ex.gnt, ex.s, ex.v, ex.y, ex.tmo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sb.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      apply(8'h00, 8'hFF);
      ex = sb.pop_front(); vectors++;
      if (bus.gnt !== ex.gnt || bus.s !== ex.s || bus.y_valid !== ex.v || bus.y !== ex.y || bus.tmo !== ex.tmo) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: gnt=%h s=%0d v=%b y=%b tmo=%b want gnt=%h s=%0d v=%b y=%b tmo=%b",
                 i, bus.gnt, bus.s, bus.y_valid, bus.y, bus.tmo, ex.gnt, ex.s, ex.v, ex.y, ex.tmo);
      end
    end
  endtask

  task automatic test_single_owner();
    logic [7:0] rq [5] = '{8'h08, 8'h08, 8'h09, 8'h09, 8'h00};
    logic [7:0] ev [5] = '{8'h08, 8'h00, 8'h00, 8'h08, 8'h00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        // e changes between edges; y must follow with no clock
        bus.e = ev[i];
        #1;
        sb.push_back(mk(8'h08, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0));
      end else if (i == 4) begin
        sb.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        apply(rq[i], ev[i]);
      end else begin
        sb.push_back(mk(8'h08, 3'd3, 1'b1, 1'b1, ev[i][3], 1'b0));
        apply(rq[i], ev[i]);
      end
      ex = sb.pop_front(); vectors++;
      if ({bus.gnt, bus.y_valid, bus.y, bus.tmo} !== {ex.gnt, ex.v, ex.y, ex.tmo} || (ex.cs && bus.s !== ex.s)) begin
        miscompares++;
        $display("FAIL single[%0d]: gnt=%h s=%0d v=%b y=%b tmo=%b want gnt=%h s=%0d v=%b y=%b tmo=%b",
                 i, bus.gnt, bus.s, bus.y_valid, bus.y, bus.tmo, ex.gnt, ex.s, ex.v, ex.y, ex.tmo);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] r;
    logic [7:0] ev;
    logic [2:0] es;
    ev = 8'hA5;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      r  = (i == 0) ? 8'hFF : (8'hFF & ~(8'h01 << ((i - 1) % 8)));
      es = 3'(i % 8);
      sb.push_back(mk(8'h01 << es, es, 1'b1, 1'b1, ev[es], 1'b0));
      apply(r, ev);
      ex = sb.pop_front(); vectors++;
      if ({bus.gnt, bus.y_valid, bus.y, bus.tmo} !== {ex.gnt, ex.v, ex.y, ex.tmo} || (ex.cs && bus.s !== ex.s)) begin
        miscompares++;
        $display("FAIL rr[%0d]: gnt=%h s=%0d v=%b y=%b tmo=%b want gnt=%h s=%0d v=%b y=%b tmo=%b",
                 i, bus.gnt, bus.s, bus.y_valid, bus.y, bus.tmo, ex.gnt, ex.s, ex.v, ex.y, ex.tmo);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [7:0] rq [4] = '{8'h20, 8'h05, 8'h04, 8'h00};
    logic [2:0] es [4] = '{3'd5, 3'd0, 3'd2, 3'd0};
    logic [3:0] vv;
    logic [7:0] ev;
    vv = 4'b0111;
    ev = 8'h24;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(vv[i] ? (8'h01 << es[i]) : 8'h00, es[i], vv[i], vv[i], vv[i] & ev[es[i]], 1'b0));
      apply(rq[i], ev);
      ex = sb.pop_front(); vectors++;
      if ({bus.gnt, bus.y_valid, bus.y, bus.tmo} !== {ex.gnt, ex.v, ex.y, ex.tmo} || (ex.cs && bus.s !== ex.s)) begin
        miscompares++;
        $display("FAIL wrap[%0d]: gnt=%h s=%0d v=%b y=%b tmo=%b want gnt=%h s=%0d v=%b y=%b tmo=%b",
                 i, bus.gnt, bus.s, bus.y_valid, bus.y, bus.tmo, ex.gnt, ex.s, ex.v, ex.y, ex.tmo);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back(mk(8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      end else begin
        if (i == 2) rst_n = 1'b1;
        sb.push_back(mk(8'h10, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0));
        apply((i == 0) ? 8'h10 : 8'h30, 8'h10);
      end
      ex = sb.pop_front(); vectors++;
      if ({bus.gnt, bus.y_valid, bus.y, bus.tmo} !== {ex.gnt, ex.v, ex.y, ex.tmo} || (ex.cs && bus.s !== ex.s)) begin
        miscompares++;
        $display("FAIL async[%0d]: gnt=%h s=%0d v=%b y=%b tmo=%b want gnt=%h s=%0d v=%b y=%b tmo=%b",
                 i, bus.gnt, bus.s, bus.y_valid, bus.y, bus.tmo, ex.gnt, ex.s, ex.v, ex.y, ex.tmo);
      end
    end
  endtask

  task automatic test_hold(input logic [7:0] r);
    logic [2:0] es;
    logic       et;
    do_reset();
    for (int i = 0; i < 13; i++) begin
`ifdef MUX8_ARB_TIMEOUT_EN
      es = (r == 8'h03) ? 3'((i / 4) % 2) : 3'd0;
      et = (i > 0) && (i % 4 == 0);
`else
      es = 3'd0;
      et = 1'b0;
`endif
      sb.push_back(mk(8'h01 << es, es, 1'b1, 1'b1, (es == 3'd1), et));
      apply(r, 8'h02);
      ex = sb.pop_front(); vectors++;
      if ({bus.gnt, bus.y_valid, bus.y, bus.tmo} !== {ex.gnt, ex.v, ex.y, ex.tmo} || (ex.cs && bus.s !== ex.s)) begin
        miscompares++;
        $display("FAIL hold_%h[%0d]: gnt=%h s=%0d v=%b y=%b tmo=%b want gnt=%h s=%0d v=%b y=%b tmo=%b",
                 r, i, bus.gnt, bus.s, bus.y_valid, bus.y, bus.tmo, ex.gnt, ex.s, ex.v, ex.y, ex.tmo);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.req     = 8'h00;
    bus.e       = 8'h00;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_wrap_skip();
    test_async_reset();
    test_hold(8'h03);
    test_hold(8'h01);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
`default_nettype wire
